branch_predict: RTL and testbench

Fetch-side PC sequencer and 2-bit dynamic branch predictor for the 8-bit core. It generates the fetch PC, predicts conditional branches from a table of saturating counters, and accepts the EX-stage resolution (the `bSel` outcome of the branch comparator) to train the table. On a wrong prediction it redirects the PC and raises a pipeline flush.

---
 rtl/branch_predict.sv | 99 +++++++++
 tb/tb_branch_predict.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict.sv
// Fetch PC sequencer with a 2-bit saturating-counter branch predictor.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predict #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 4,
    parameter int INC   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    input  logic            f_br,
    input  logic [PC_W-1:0] f_target,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_taken,
    input  logic            ex_pred,
    output logic            flush,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispred
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    ctr_t             table_q [DEPTH];
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [PC_W-1:0]  pc_next;

    // Bit 0 of a PC is always zero for INC-aligned instructions, so it is skipped.
    assign f_idx  = pc[IDX_W:1];
    assign ex_idx = ex_pc[IDX_W:1];

    assign pred_taken = f_br & table_q[f_idx][1];
    assign flush      = ex_valid & (ex_taken != ex_pred);

    // NOTE: pc_next is assigned on every path, so no latch is inferred.
    always_comb begin
        pc_next = pc + PC_W'(INC);
        if (flush && ex_taken)
            pc_next = ex_target;
        else if (flush)
            pc_next = ex_pc + PC_W'(INC);
        else if (stall)
            pc_next = pc;
        else if (pred_taken)
            pc_next = f_target;
    end

    // NOTE: the predictor table is a small register file, so it is reset
    // explicitly; a RAM-style table would have no reset and need an init walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < DEPTH; i++)
                table_q[i] <= WEAK_NT;
        end else begin
            pc <= pc_next;
            if (ex_valid) begin
                if (ex_taken && table_q[ex_idx] != STRONG_T)
                    table_q[ex_idx] <= ctr_t'(table_q[ex_idx] + 2'd1);
                else if (!ex_taken && table_q[ex_idx] != STRONG_NT)
                    table_q[ex_idx] <= ctr_t'(table_q[ex_idx] - 2'd1);
            end
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] br_cnt;
    logic [15:0] mis_cnt;

    // Both counters wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (ex_valid) br_cnt  <= br_cnt + 16'd1;
            if (flush)    mis_cnt <= mis_cnt + 16'd1;
        end
    end

    assign stat_branches = br_cnt;
    assign stat_mispred  = mis_cnt;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predict.sv
// Self-checking bench for branch_predict: directed scenarios pinned with
// literal expectations plus randomized traffic against a behavioural model.
module tb_branch_predict;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [15:0] pc;
    logic        f_br;
    logic [15:0] f_target;
    logic        pred_taken;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic [15:0] ex_target;
    logic        ex_taken;
    logic        ex_pred;
    logic        flush;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    int n_vec = 0;
    int n_err = 0;

`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    branch_predict dut (
        .clk(clk), .rst(rst), .stall(stall), .pc(pc),
        .f_br(f_br), .f_target(f_target), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_taken(ex_taken), .ex_pred(ex_pred), .flush(flush),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counters as plain integers 0..3, PC as an integer mod 65536.
    int m_ctr [16];
    int m_pc, m_br, m_mis;

    function automatic bit m_pred();
        return f_br && (m_ctr[(m_pc / 2) % 16] >= 2);
    endfunction

    function automatic bit m_flush();
        return ex_valid && (ex_taken != ex_pred);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 0; m_br = 0; m_mis = 0;
            for (int i = 0; i < 16; i++) m_ctr[i] = 1;
        end else begin
            int nxt;
            int k;
            if (m_flush() && ex_taken)  nxt = int'(ex_target);
            else if (m_flush())         nxt = (int'(ex_pc) + 2) % 65536;
            else if (stall)             nxt = m_pc;
            else if (m_pred())          nxt = int'(f_target);
            else                        nxt = (m_pc + 2) % 65536;
            if (ex_valid) begin
                k = (int'(ex_pc) / 2) % 16;
                m_ctr[k] = ex_taken ? ((m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1)
                                    : ((m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1);
                if (STATS) m_br = (m_br + 1) % 65536;
            end
            if (STATS && m_flush()) m_mis = (m_mis + 1) % 65536;
            m_pc = nxt;
        end
    end

    // Single compare process: all outputs against the model every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("model_pc", 32'(pc), 32'(m_pc));
            check("model_pred", 32'(pred_taken), 32'(m_pred()));
            check("model_flush", 32'(flush), 32'(m_flush()));
            check("model_stat_br", 32'(stat_branches), 32'(m_br));
            check("model_stat_mis", 32'(stat_mispred), 32'(m_mis));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; f_br = 0; f_target = 0;
        ex_valid = 0; ex_pc = 0; ex_target = 0; ex_taken = 0; ex_pred = 0;
    endtask

    task automatic resolve(input logic [15:0] p, input logic [15:0] t, input logic tk, input logic pr);
        ex_valid = 1; ex_pc = p; ex_target = t; ex_taken = tk; ex_pred = pr;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; idle(); f_br = 1;
        #3;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_pred", 32'(pred_taken), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        tick(); tick();
        rst = 0;
        @(negedge clk); check("seq_pc0", 32'(pc), 32'h0000);
        tick(); @(negedge clk); check("seq_pc1", 32'(pc), 32'h0002);
        tick(); @(negedge clk); check("seq_pc2", 32'(pc), 32'h0004);
        tick();

        // Train index 8 to strong taken, then redirect fetch onto it.
        idle(); resolve(16'h0010, 16'h0000, 1, 1); tick(); tick();
        resolve(16'h0002, 16'h0010, 1, 0);
        @(negedge clk); check("redir_flush", 32'(flush), 32'h1);
        tick();
        idle(); f_br = 1; f_target = 16'h0080;
        @(negedge clk);
        check("train_pc", 32'(pc), 32'h0010);
        check("train_pred", 32'(pred_taken), 32'h1);
        tick(); idle();
        @(negedge clk); check("train_target", 32'(pc), 32'h0080);

        // Mispredicts override stall.
        stall = 1; resolve(16'h0004, 16'h0040, 1, 0);
        @(negedge clk); check("mis_t_flush", 32'(flush), 32'h1);
        tick();
        @(negedge clk); check("mis_t_pc", 32'(pc), 32'h0040);
        resolve(16'h0020, 16'h0000, 0, 1);
        @(negedge clk); check("mis_nt_flush", 32'(flush), 32'h1);
        tick(); idle();
        @(negedge clk); check("mis_nt_pc", 32'(pc), 32'h0022);

        // Saturation on index 5.
        stall = 1;
        repeat (5) begin resolve(16'h000A, 16'h0000, 1, 1); tick(); end
        resolve(16'h0040, 16'h000A, 1, 0); tick();
        idle(); stall = 1; f_br = 1; f_target = 16'h0100;
        @(negedge clk);
        check("sat_hi_pc", 32'(pc), 32'h000A);
        check("sat_hi_pred", 32'(pred_taken), 32'h1);
        repeat (5) begin resolve(16'h000A, 16'h0000, 0, 0); tick(); end
        resolve(16'h000A, 16'h0000, 1, 1);
        @(negedge clk); check("sat_lo_pred", 32'(pred_taken), 32'h0);
        tick(); idle(); stall = 1; f_br = 1;
        @(negedge clk); check("sat_lo_inc", 32'(pred_taken), 32'h0);

        // Same-cycle lookup/update on index 3: no bypass.
        idle(); resolve(16'h0040, 16'h0006, 1, 0); tick();
        idle(); stall = 1; f_br = 1; resolve(16'h0006, 16'h0000, 1, 1);
        @(negedge clk);
        check("haz_pc", 32'(pc), 32'h0006);
        check("haz_old", 32'(pred_taken), 32'h0);
        tick(); idle(); stall = 1; f_br = 1;
        @(negedge clk); check("haz_new", 32'(pred_taken), 32'h1);

        // PC wrap.
        idle(); resolve(16'h0040, 16'hFFFE, 1, 0); tick(); idle();
        @(negedge clk); check("wrap_pre", 32'(pc), 32'hFFFE);
        tick();
        @(negedge clk); check("wrap_post", 32'(pc), 32'h0000);

        // Mid-operation async reset discards the pending resolution.
        resolve(16'h0010, 16'h0000, 0, 1);
        #2 rst = 1;
        #1 check("async_pc", 32'(pc), 32'h0);
        check("async_stat", 32'(stat_branches), 32'h0);
        tick(); idle(); rst = 0;
        @(negedge clk); check("post_rst_mis", 32'(stat_mispred), 32'h0);

        // Statistics: 10 resolutions, 3 mispredicts.
        for (int i = 0; i < 10; i++) begin
            stall = 1;
            resolve(16'(2 * i), 16'h0100, 1'(i % 2), (i < 3) ? ~1'(i % 2) : 1'(i % 2));
            tick();
        end
        idle();
        @(negedge clk);
        check("stat_br", 32'(stat_branches), STATS ? 32'd10 : 32'd0);
        check("stat_mis", 32'(stat_mispred), STATS ? 32'd3 : 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            f_br     = $urandom_range(0, 1) == 1;
            f_target = 16'($urandom) & 16'hFFFE;
            ex_valid = ($urandom_range(0, 2) != 0);
            ex_pc    = 16'($urandom) & 16'hFFFE;
            ex_target = 16'($urandom) & 16'hFFFE;
            ex_taken = $urandom_range(0, 1) == 1;
            ex_pred  = ($urandom_range(0, 3) == 0) ? ~ex_taken : ex_taken;
            tick();
        end
        idle(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
